// File: rtl/matrix_pixel_fetch_pkg.sv
// Shared constants for matrix_pixel_fetch: RGB565 field positions, panel geometry,
// bit-plane mask width and FSM state encodings.
package matrix_pixel_fetch_pkg;

    localparam int unsigned PANEL_COLUMNS   = 64;
    localparam int unsigned PANEL_ROWS_HALF = 16;
    localparam int unsigned MASK_WIDTH      = 6;

    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic mask_is_onehot(input logic [MASK_WIDTH-1:0] m);
        return ($countones(m) == 1);
    endfunction

endpackage

// File: rtl/matrix_pixel_fetch_plane_bit.sv
// rgb565_plane_bit: reduces one RGB565 word to an {R,G,B} on/off triple for the
// bit-plane selected by a one-hot mask. Purely combinational.
module rgb565_plane_bit
    import matrix_pixel_fetch_pkg::*;
(
    input  logic [15:0]           pixel_i,
    input  logic [MASK_WIDTH-1:0] mask_i,
    output logic [2:0]            rgb_o
);

    logic [MASK_WIDTH-1:0] r6;
    logic [MASK_WIDTH-1:0] g6;
    logic [MASK_WIDTH-1:0] b6;

    always_comb begin
        // 5-bit channels are widened by repeating their MSB into the new LSB.
        r6    = {pixel_i[R_MSB:R_LSB], pixel_i[R_MSB]};
        g6    = pixel_i[G_MSB:G_LSB];
        b6    = {pixel_i[B_MSB:B_LSB], pixel_i[B_MSB]};
        rgb_o = {|(r6 & mask_i), |(g6 & mask_i), |(b6 & mask_i)};
    end

endmodule

// File: rtl/matrix_pixel_fetch.sv
// matrix_pixel_fetch: per-line framebuffer read and bit-plane reduction for the LED panel.
// Define FB_DOUBLE_BUFFER_EN to enable framebuffer swapping at frame boundaries.
module matrix_pixel_fetch
    import matrix_pixel_fetch_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [5:0]            column_address,
    input  logic [3:0]            row_address,
    input  logic [MASK_WIDTH-1:0] brightness_mask,
    output logic [10:0]           ram_addr,
    output logic                  ram_rd_en,
    input  logic [31:0]           ram_data,
    output logic [2:0]            rgb_top,
    output logic [2:0]            rgb_bottom,
    output logic                  pixel_valid,
    output logic                  line_done,
    output logic                  mask_error,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  frame_select
);

    logic [1:0]             state_q, state_d;
    logic [3:0]             line_row_q, line_row_d;
    logic [MASK_WIDTH-1:0]  line_mask_q, line_mask_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic [10:0]            ram_addr_q, ram_addr_d;
    logic                   ram_rd_en_q, ram_rd_en_d;
    logic                   line_done_q, line_done_d;
    logic                   mask_error_q, mask_error_d;
    logic [RAM_LATENCY-1:0] vld_q;
    logic [2:0]             rgb_top_q, rgb_bot_q;
    logic                   pixel_valid_q;
    logic [2:0]             plane_top, plane_bot;
    logic                   line_bad;
    logic                   fb_sel;

    assign line_bad = !mask_is_onehot(line_mask_q);

    always_comb begin
        state_d      = state_q;
        line_row_d   = line_row_q;
        line_mask_d  = line_mask_q;
        drain_cnt_d  = drain_cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_rd_en_d  = 1'b0;
        line_done_d  = 1'b0;
        mask_error_d = mask_error_q;
        unique case (state_q)
            ST_IDLE: begin
                // The first read of a line uses the live row, as it is latched this same cycle.
                if (load_en) begin
                    state_d      = ST_FETCH;
                    line_row_d   = row_address;
                    line_mask_d  = brightness_mask;
                    mask_error_d = mask_error_q | !mask_is_onehot(brightness_mask);
                    ram_rd_en_d  = 1'b1;
                    ram_addr_d   = {fb_sel, row_address, column_address};
                end
            end
            ST_FETCH: begin
                if (load_en) begin
                    ram_rd_en_d = 1'b1;
                    ram_addr_d  = {fb_sel, line_row_q, column_address};
                end else begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 2'(RAM_LATENCY)) begin
                    line_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rgb565_plane_bit u_plane_top (
        .pixel_i (ram_data[15:0]),
        .mask_i  (line_mask_q),
        .rgb_o   (plane_top)
    );

    rgb565_plane_bit u_plane_bot (
        .pixel_i (ram_data[31:16]),
        .mask_i  (line_mask_q),
        .rgb_o   (plane_bot)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            line_row_q    <= '0;
            line_mask_q   <= '0;
            drain_cnt_q   <= '0;
            ram_addr_q    <= '0;
            ram_rd_en_q   <= 1'b0;
            line_done_q   <= 1'b0;
            mask_error_q  <= 1'b0;
            vld_q         <= '0;
            rgb_top_q     <= '0;
            rgb_bot_q     <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_row_q   <= line_row_d;
            line_mask_q  <= line_mask_d;
            drain_cnt_q  <= drain_cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_rd_en_q  <= ram_rd_en_d;
            line_done_q  <= line_done_d;
            mask_error_q <= mask_error_d;
            // vld_q[RAM_LATENCY-1] lines up with the cycle ram_data is valid.
            vld_q[0] <= ram_rd_en_q;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            pixel_valid_q <= vld_q[RAM_LATENCY-1];
            rgb_top_q     <= (vld_q[RAM_LATENCY-1] && !line_bad) ? plane_top : '0;
            rgb_bot_q     <= (vld_q[RAM_LATENCY-1] && !line_bad) ? plane_bot : '0;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic fb_sel_q;
    logic swap_ack_q;
    logic swap_armed_q;
    logic swap_now;

    // Swap only as the last plane of the last row retires; one swap per swap_req assertion.
    assign swap_now = line_done_d && swap_req && swap_armed_q &&
                      (line_row_q == 4'(PANEL_ROWS_HALF - 1)) &&
                      (line_mask_q == MASK_WIDTH'(1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            fb_sel_q     <= 1'b0;
            swap_ack_q   <= 1'b0;
            swap_armed_q <= 1'b1;
        end else begin
            swap_ack_q <= swap_now;
            if (swap_now) begin
                fb_sel_q     <= ~fb_sel_q;
                swap_armed_q <= 1'b0;
            end else if (!swap_req) begin
                swap_armed_q <= 1'b1;
            end
        end
    end

    assign fb_sel   = fb_sel_q;
    assign swap_ack = swap_ack_q;
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign fb_sel          = 1'b0;
    assign swap_ack        = 1'b0;
`endif

    assign ram_addr     = ram_addr_q;
    assign ram_rd_en    = ram_rd_en_q;
    assign rgb_top      = rgb_top_q;
    assign rgb_bottom   = rgb_bot_q;
    assign pixel_valid  = pixel_valid_q;
    assign line_done    = line_done_q;
    assign mask_error   = mask_error_q;
    assign frame_select = fb_sel;

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Self-checking bench for matrix_pixel_fetch: randomized framebuffer contents and lines
// compared against a line-level reference model; honours FB_DOUBLE_BUFFER_EN if defined.
`timescale 1ns/1ps
module tb_matrix_pixel_fetch;

    localparam int unsigned LAT = 1;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        load_en;
    logic [5:0]  column_address;
    logic [3:0]  row_address;
    logic [5:0]  brightness_mask;
    logic [10:0] ram_addr;
    logic        ram_rd_en;
    logic [31:0] ram_data;
    logic [2:0]  rgb_top;
    logic [2:0]  rgb_bottom;
    logic        pixel_valid;
    logic        line_done;
    logic        mask_error;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_select;

    always #5 clk_in = ~clk_in;

    matrix_pixel_fetch #(.RAM_LATENCY(LAT)) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .load_en         (load_en),
        .column_address  (column_address),
        .row_address     (row_address),
        .brightness_mask (brightness_mask),
        .ram_addr        (ram_addr),
        .ram_rd_en       (ram_rd_en),
        .ram_data        (ram_data),
        .rgb_top         (rgb_top),
        .rgb_bottom      (rgb_bottom),
        .pixel_valid     (pixel_valid),
        .line_done       (line_done),
        .mask_error      (mask_error),
        .swap_req        (swap_req),
        .swap_ack        (swap_ack),
        .frame_select    (frame_select)
    );

    // Framebuffer RAM with LAT cycles of read latency.
    logic [31:0] mem [0:2047];
    logic [31:0] rd_pipe [0:LAT-1];

    always @(posedge clk_in) begin
        if (ram_rd_en) rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_data = rd_pipe[LAT-1];

    int n_assert = 0;
    int n_fail   = 0;
    bit fs_exp    = 1'b0;
    bit armed_exp = 1'b1;
    bit merr_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: expand channel to 6 bits, pick the bit named by the one-hot mask.
    function automatic logic [2:0] ref_plane(input logic [15:0] px, input logic [5:0] m);
        int k, r, g, b;
        if ($countones(m) != 1) return 3'b000;
        k = 0;
        for (int i = 0; i < 6; i++) if (m[i]) k = i;
        r = int'(px[15:11]);
        g = int'(px[10:5]);
        b = int'(px[4:0]);
        r = r * 2 + r / 16;
        b = b * 2 + b / 16;
        return {1'(r >> k), 1'(g >> k), 1'(b >> k)};
    endfunction

    task automatic check_reset_vals(input string where);
        chk({where, ":ram_addr"},     ram_addr,     0);
        chk({where, ":ram_rd_en"},    ram_rd_en,    0);
        chk({where, ":rgb_top"},      rgb_top,      0);
        chk({where, ":rgb_bottom"},   rgb_bottom,   0);
        chk({where, ":pixel_valid"},  pixel_valid,  0);
        chk({where, ":line_done"},    line_done,    0);
        chk({where, ":mask_error"},   mask_error,   0);
        chk({where, ":swap_ack"},     swap_ack,     0);
        chk({where, ":frame_select"}, frame_select, 0);
    endtask

    // Drives one 64-column line starting just after a rising edge; checks every cycle.
    // abort_at >= 0 asserts reset in that cycle and returns.
    task automatic run_line(input logic [3:0] row, input logic [5:0] mask,
                            input bit sreq, input int abort_at);
        bit          bad;
        bit          merr_before;
        bit          swap_exp;
        bit          pv_exp;
        int          last;
        logic [5:0]  col;
        logic [31:0] word;
        bad         = ($countones(mask) != 1);
        merr_before = merr_exp;
        last        = 66 + LAT + 2;
        if (!sreq) armed_exp = 1'b1;
        swap_req = sreq;
        swap_exp = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
        swap_exp = sreq && armed_exp && (row == 4'd15) && (mask == 6'd1);
`endif
        for (int c = 0; c <= last; c++) begin
            load_en         = (c < 64);
            column_address  = (c < 64) ? 6'(63 - c) : 6'($urandom);
            row_address     = (c == 0) ? row  : 4'($urandom);
            brightness_mask = (c == 0) ? mask : 6'($urandom);
            @(negedge clk_in);
            chk("ram_rd_en", ram_rd_en, (c >= 1 && c <= 64));
            if (c >= 1 && c <= 64) chk("ram_addr", ram_addr, {fs_exp, row, 6'(64 - c)});
            pv_exp = (c >= 2 + LAT && c <= 65 + LAT);
            chk("pixel_valid", pixel_valid, pv_exp);
            if (pv_exp) begin
                col  = 6'(63 - (c - 2 - int'(LAT)));
                word = mem[{fs_exp, row, col}];
                chk("rgb_top",    rgb_top,    ref_plane(word[15:0],  mask));
                chk("rgb_bottom", rgb_bottom, ref_plane(word[31:16], mask));
            end
            chk("line_done",    line_done,    (c == 66 + LAT));
            chk("mask_error",   mask_error,   merr_before | (bad && c >= 1));
            chk("swap_ack",     swap_ack,     swap_exp && (c == 66 + LAT));
            chk("frame_select", frame_select, fs_exp ^ (swap_exp && c >= 66 + LAT));
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_vals("midline_reset");
                load_en = 1'b0;
                return;
            end
            @(posedge clk_in);
            #1;
        end
        fs_exp   = fs_exp ^ swap_exp;
        if (swap_exp) armed_exp = 1'b0;
        merr_exp = merr_exp | bad;
    endtask

    initial begin
        reset           = 1'b0;
        load_en         = 1'b0;
        column_address  = '0;
        row_address     = '0;
        brightness_mask = '0;
        swap_req        = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        for (int i = 0; i < 64; i++) begin
            mem[{1'b0, 4'd3, 6'(i)}][15:0] = 16'hF800;
            mem[{1'b0, 4'd5, 6'(i)}]       = {16'h07E0, 16'h8831};
        end

        repeat (3) @(posedge clk_in);
        #1;
        check_reset_vals("in_reset");
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            check_reset_vals("idle");
        end
        @(posedge clk_in);
        #1;

        run_line(4'd3, 6'b100000, 1'b0, -1);
        run_line(4'd5, 6'b000001, 1'b0, -1);
        repeat (4) run_line(4'($urandom_range(0, 15)), 6'(1 << $urandom_range(0, 5)), 1'b0, -1);

        run_line(4'd14, 6'b000001, 1'b1, -1);
        run_line(4'd15, 6'b000010, 1'b1, -1);
        run_line(4'd15, 6'b000001, 1'b1, -1);
        run_line(4'd0,  6'b100000, 1'b1, -1);
        run_line(4'd15, 6'b000001, 1'b1, -1);
        run_line(4'd2,  6'b000100, 1'b0, -1);
        run_line(4'd15, 6'b000001, 1'b1, -1);

        run_line(4'd7, 6'b000011, 1'b0, -1);
        run_line(4'd8, 6'b001000, 1'b0, -1);
        run_line(4'd9, 6'b000000, 1'b0, -1);

        run_line(4'd4, 6'b010000, 1'b0, 32 + LAT);
        fs_exp    = 1'b0;
        armed_exp = 1'b1;
        merr_exp  = 1'b0;
        swap_req  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_in);
            chk("post_reset_pixel_valid", pixel_valid, 0);
            chk("post_reset_line_done",   line_done,   0);
            chk("post_reset_ram_rd_en",   ram_rd_en,   0);
        end
        @(posedge clk_in);
        #1;
        run_line(4'd6, 6'b000100, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
